// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundles the fetch port, the load/store port and the RAM
//                command/response signals of mem_arbiter. The slave modport
//                is the arbiter's view; the master modport is the view of the
//                surrounding CPU and RAM.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Instruction-fetch port
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;

  // Load/store port
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  // Shared RAM command and read data
  logic          ram_en;
  logic          ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  // Arbiter status
  logic          busy;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    input  ram_rdata,
    output i_ack, i_rdata,
    output d_ack, d_rdata,
    output ram_en, ram_we, ram_be, ram_addr, ram_wdata,
    output busy
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    output ram_rdata,
    input  i_ack, i_rdata,
    input  d_ack, d_rdata,
    input  ram_en, ram_we, ram_be, ram_addr, ram_wdata,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester arbiter sharing one synchronous single-port
//                RAM between instruction fetch (I) and load/store (D).
//                Accesses are serialised through an IDLE/GRANT/RESP FSM; the
//                RAM command is registered in GRANT and the owner receives a
//                one-cycle ack with read data in RESP.
//                Compile option MEM_ARB_RR_EN: when defined, ties in IDLE go
//                to the requester that did not win last time (round-robin);
//                when undefined, D always wins ties (fixed priority).
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic         clock,
  input  logic         reset,   // asynchronous, active low
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Requester encoding used by last_grant and the winner select
  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

  state_t        state;
  state_t        state_nxt;

  // last_grant doubles as the owner of the access in flight
  logic          last_grant;

  logic          i_elig;
  logic          d_elig;
  logic          grant_go;
  logic          grant_sel;

  logic          ram_en_q;
  logic          ram_we_q;
  logic [3:0]    ram_be_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_wdata_q;

  logic          i_ack_w;
  logic          d_ack_w;

  // Eligibility, winner selection and next-state decode
  always_comb begin
    state_nxt = state;
    i_elig    = 1'b0;
    d_elig    = 1'b0;
    grant_sel = SEL_I;

    case (state)
      IDLE: begin
        i_elig = bus.i_req;
        d_elig = bus.d_req;
      end
      RESP: begin
        // The owner's request is ignored while its ack is being returned,
        // so a requester holding req into the ack cycle is not re-served.
        i_elig = bus.i_req && (last_grant == SEL_D);
        d_elig = bus.d_req && (last_grant == SEL_I);
      end
      default: begin
        i_elig = 1'b0;
        d_elig = 1'b0;
      end
    endcase

    grant_go = i_elig || d_elig;

    if (i_elig && d_elig) begin
      // A tie can only occur in IDLE; in RESP only the non-owner competes.
`ifdef MEM_ARB_RR_EN
      grant_sel = (last_grant == SEL_I) ? SEL_D : SEL_I;
`else
      grant_sel = SEL_D;
`endif
    end else if (d_elig) begin
      grant_sel = SEL_D;
    end else begin
      grant_sel = SEL_I;
    end

    case (state)
      IDLE:    state_nxt = grant_go ? GRANT : IDLE;
      GRANT:   state_nxt = RESP;
      RESP:    state_nxt = grant_go ? GRANT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // RAM command registers and grant history, loaded on every GRANT entry
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_be_q    <= 4'h0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      last_grant  <= SEL_I;
    end else if (grant_go) begin
      ram_en_q   <= 1'b1;
      last_grant <= grant_sel;
      if (grant_sel == SEL_D) begin
        ram_we_q    <= bus.d_we;
        ram_be_q    <= bus.d_be;
        ram_addr_q  <= bus.d_addr;
        ram_wdata_q <= bus.d_wdata;
      end else begin
        // Fetches are always reads with no byte lanes enabled
        ram_we_q    <= 1'b0;
        ram_be_q    <= 4'h0;
        ram_addr_q  <= bus.i_addr;
        ram_wdata_q <= '0;
      end
    end else begin
      // Strobes last exactly one cycle; address/data are simply held
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
    end
  end

  // Acks are decoded from the RESP state so a reset removes them at once
  always_comb begin
    i_ack_w = (state == RESP) && (last_grant == SEL_I);
    d_ack_w = (state == RESP) && (last_grant == SEL_D);
  end

  assign bus.i_ack     = i_ack_w;
  assign bus.d_ack     = d_ack_w;
  assign bus.i_rdata   = i_ack_w ? bus.ram_rdata : '0;
  assign bus.d_rdata   = d_ack_w ? bus.ram_rdata : '0;

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_be    = ram_be_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;

  assign bus.busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter with a small
//                behavioural synchronous RAM (read-first, byte enables).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:1023];
  int vectors     = 0;
  int miscompares = 0;

  // Behavioural RAM: read data appears the cycle after ram_en
  always @(posedge clock) begin
    if (bus.ram_en) begin
      bus.ram_rdata <= mem[bus.ram_addr[9:0]];
      if (bus.ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.ram_be[b]) mem[bus.ram_addr[9:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic        d_first;
  logic [31:0] exp_addr;
  logic [1:0]  exp_ack;
  int          ack_count;

  initial begin
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_be    = 4'h0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
    mem[16] = 32'h00500093;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst ram_en",    32'(bus.ram_en),    32'd0);
    check("rst ram_we",    32'(bus.ram_we),    32'd0);
    check("rst ram_be",    32'(bus.ram_be),    32'd0);
    check("rst ram_addr",  bus.ram_addr,       32'd0);
    check("rst ram_wdata", bus.ram_wdata,      32'd0);
    check("rst i_ack",     32'(bus.i_ack),     32'd0);
    check("rst d_ack",     32'(bus.d_ack),     32'd0);
    check("rst i_rdata",   bus.i_rdata,        32'd0);
    check("rst d_rdata",   bus.d_rdata,        32'd0);
    check("rst busy",      32'(bus.busy),      32'd0);
    reset = 1'b1;
    tick();

    // ---------------- isolated fetch ----------------
    bus.i_addr = 32'h10;
    bus.i_req  = 1'b1;
    tick();
    check("fetch c1 ram_en",   32'(bus.ram_en), 32'd1);
    check("fetch c1 ram_addr", bus.ram_addr,    32'h10);
    check("fetch c1 ram_we",   32'(bus.ram_we), 32'd0);
    check("fetch c1 ram_be",   32'(bus.ram_be), 32'd0);
    check("fetch c1 i_ack",    32'(bus.i_ack),  32'd0);
    check("fetch c1 busy",     32'(bus.busy),   32'd1);
    tick();
    check("fetch c2 i_ack",    32'(bus.i_ack),  32'd1);
    check("fetch c2 i_rdata",  bus.i_rdata,     32'h00500093);
    check("fetch c2 d_ack",    32'(bus.d_ack),  32'd0);
    check("fetch c2 ram_en",   32'(bus.ram_en), 32'd0);
    bus.i_req = 1'b0;
    tick();
    check("fetch c3 busy",     32'(bus.busy),   32'd0);
    check("fetch c3 i_rdata",  bus.i_rdata,     32'd0);

    // ---------------- full-word store, then fetch it back ----------------
    bus.d_addr  = 32'h200;
    bus.d_wdata = 32'hDEADBEEF;
    bus.d_be    = 4'hF;
    bus.d_we    = 1'b1;
    bus.d_req   = 1'b1;
    tick();
    check("store c1 ram_en",    32'(bus.ram_en), 32'd1);
    check("store c1 ram_we",    32'(bus.ram_we), 32'd1);
    check("store c1 ram_be",    32'(bus.ram_be), 32'hF);
    check("store c1 ram_addr",  bus.ram_addr,    32'h200);
    check("store c1 ram_wdata", bus.ram_wdata,   32'hDEADBEEF);
    tick();
    check("store c2 d_ack",     32'(bus.d_ack),  32'd1);
    check("store c2 i_ack",     32'(bus.i_ack),  32'd0);
    check("store c2 ram_we",    32'(bus.ram_we), 32'd0);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick();
    bus.i_addr = 32'h200;
    bus.i_req  = 1'b1;
    tick();
    tick();
    check("refetch i_ack",   32'(bus.i_ack), 32'd1);
    check("refetch i_rdata", bus.i_rdata,    32'hDEADBEEF);
    bus.i_req = 1'b0;
    tick();

    // ---------------- simultaneous requests, last_grant = I ----------------
    bus.i_addr  = 32'h10;
    bus.d_addr  = 32'h200;
    bus.d_we    = 1'b0;
    bus.d_be    = 4'h0;
    bus.i_req   = 1'b1;
    bus.d_req   = 1'b1;
    tick();
    check("tie c1 ram_addr", bus.ram_addr, 32'h200);
    tick();
    check("tie c2 acks",    32'({bus.i_ack, bus.d_ack}), 32'b01);
    check("tie c2 d_rdata", bus.d_rdata, 32'hDEADBEEF);
    bus.d_req = 1'b0;
    tick();
    check("tie c3 ram_en",   32'(bus.ram_en), 32'd1);
    check("tie c3 ram_addr", bus.ram_addr,    32'h10);
    tick();
    check("tie c4 acks",    32'({bus.i_ack, bus.d_ack}), 32'b10);
    check("tie c4 i_rdata", bus.i_rdata, 32'h00500093);
    bus.i_req = 1'b0;
    tick();
    check("tie c5 busy", 32'(bus.busy), 32'd0);

    // ---------------- both held for 8 accesses: D,I,D,I,... ----------------
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    for (int j = 0; j < 8; j++) begin
      exp_addr = (j % 2 == 0) ? 32'h200 : 32'h10;
      exp_ack  = (j % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      check($sformatf("stream%0d grant ram_en", j), 32'(bus.ram_en), 32'd1);
      check($sformatf("stream%0d grant addr", j), bus.ram_addr, exp_addr);
      check($sformatf("stream%0d grant acks", j), 32'({bus.i_ack, bus.d_ack}), 32'b00);
      tick();
      check($sformatf("stream%0d resp acks", j), 32'({bus.i_ack, bus.d_ack}), 32'(exp_ack));
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    tick();
    check("stream end busy", 32'(bus.busy), 32'd0);

    // ---------------- partial store, load via D (last_grant = D) ----------------
    bus.d_addr  = 32'h200;
    bus.d_wdata = 32'h11223344;
    bus.d_be    = 4'b0011;
    bus.d_we    = 1'b1;
    bus.d_req   = 1'b1;
    tick();
    check("pstore c1 ram_be", 32'(bus.ram_be), 32'h3);
    tick();
    check("pstore c2 d_ack", 32'(bus.d_ack), 32'd1);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    bus.d_be  = 4'h0;
    tick();
    bus.d_req = 1'b1;
    tick();
    check("load c1 ram_we", 32'(bus.ram_we), 32'd0);
    tick();
    check("load c2 d_ack",   32'(bus.d_ack), 32'd1);
    check("load c2 d_rdata", bus.d_rdata,    32'hDEAD3344);
    check("load c2 i_rdata", bus.i_rdata,    32'd0);
    bus.d_req = 1'b0;
    tick();

    // ---------------- tie after a D grant: mode dependent ----------------
`ifdef MEM_ARB_RR_EN
    d_first = 1'b0;
`else
    d_first = 1'b1;
`endif
    bus.i_addr = 32'h10;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    tick();
    check("tie2 c1 ram_addr", bus.ram_addr, d_first ? 32'h200 : 32'h10);
    tick();
    check("tie2 c2 acks", 32'({bus.i_ack, bus.d_ack}), d_first ? 32'b01 : 32'b10);
    if (d_first) bus.d_req = 1'b0; else bus.i_req = 1'b0;
    tick();
    check("tie2 c3 ram_addr", bus.ram_addr, d_first ? 32'h10 : 32'h200);
    tick();
    check("tie2 c4 acks", 32'({bus.i_ack, bus.d_ack}), d_first ? 32'b10 : 32'b01);
    check("tie2 c4 rdata", d_first ? bus.i_rdata : bus.d_rdata,
          d_first ? 32'h00500093 : 32'hDEAD3344);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    tick();

    // ---------------- reset during a fetch GRANT ----------------
    bus.i_addr = 32'h10;
    bus.i_req  = 1'b1;
    tick();
    check("rstmid c1 ram_en", 32'(bus.ram_en), 32'd1);
    reset = 1'b0;
    #1;
    check("rstmid ram_en",   32'(bus.ram_en), 32'd0);
    check("rstmid ram_addr", bus.ram_addr,    32'd0);
    check("rstmid busy",     32'(bus.busy),   32'd0);
    tick();
    check("rstmid held i_ack", 32'(bus.i_ack), 32'd0);
    #2;
    reset = 1'b1;
    tick();
    check("rstmid restart ram_en", 32'(bus.ram_en), 32'd1);
    tick();
    check("rstmid restart i_ack",  32'(bus.i_ack),  32'd1);
    check("rstmid restart rdata",  bus.i_rdata,     32'h00500093);
    bus.i_req = 1'b0;
    tick();

    // ---------------- i_req held through its ack cycle ----------------
    ack_count  = 0;
    bus.i_req  = 1'b1;
    tick();
    ack_count += int'(bus.i_ack);
    tick();
    ack_count += int'(bus.i_ack);
    check("hold c2 i_ack", 32'(bus.i_ack), 32'd1);
    tick();
    ack_count += int'(bus.i_ack);
    check("hold c3 busy",   32'(bus.busy),   32'd0);
    check("hold c3 ram_en", 32'(bus.ram_en), 32'd0);
    bus.i_req = 1'b0;
    tick();
    ack_count += int'(bus.i_ack);
    check("hold c4 ram_en", 32'(bus.ram_en), 32'd0);
    check("hold ack count", 32'(ack_count),  32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
